rr_mux_sel_sequencer: RTL and testbench
=======================================

Name: rr_mux_sel_sequencer

Overview:
- Upstream control stage for the decoder-based 4:1 tristate mux.
- Round-robin arbitrates four request lines and drives the mux enable and select lines (en, s0, s1).
- Holds each grant for a bounded dwell time.
- Inserts a one-cycle break-before-make gap (en=0) between grants so no two tristate buffers in the mux drive at once.

Parameters:
- DWELL, 4: maximum consecutive cycles a grant is held. Legal range 1..255. DWELL=0 is illegal.
- CW, 8: width of the internal dwell counter. Must satisfy 2^CW >= DWELL.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- req  input  4  per-channel request; req[i] asks for mux input i
- en   output 1  mux enable; 1 only in GRANT
- s0   output 1  select MSB (decoder input a)
- s1   output 1  select LSB (decoder input b)
- gnt  output 4  one-hot grant, equal to decode of {s0,s1} when en=1, else 0
- busy output 1  1 in GRANT or GAP

Behaviour:
- Clocking: one clock; rst is asynchronous and active-high. All outputs are registered, with no combinational path from req to any output.
- Reset values (immediate on rst assertion, regardless of clk):
  - state=IDLE, en=0, s0=0, s1=0, gnt=4'b0000, busy=0.
  - last=3, so channel 0 wins the first arbitration. cnt=0.
- Channel index: sel = {s0,s1}. Channel 2 = s0=1, s1=0.
- Arbitration function: scan channels (last+1)%4, (last+2)%4, (last+3)%4, last. Pick the first with req=1; wraps 3->0.
- IDLE:
  - en=0, gnt=0.
  - At a rising edge with req!=0: load sel with the arbitration result, cnt=0, go to GRANT. en/gnt are valid after that same edge (1-cycle latency from sampled req).
  - With req=0: stay in IDLE.
- GRANT:
  - en=1, gnt=onehot(sel). cnt increments each edge.
  - Exit to GAP at the edge where cnt==DWELL-1, or where req[sel]==0 is sampled. Both conditions on the same edge produce a single exit.
  - On exit: en=0, gnt=0, last=sel. s0/s1 hold their last value during GAP.
  - Requests on other channels are ignored while in GRANT and have no effect on timing.
- GAP:
  - Lasts exactly one cycle; en=0, busy=1.
  - At its exiting edge, arbitrate with the updated last. If req!=0, go to GRANT with the new sel and cnt=0; otherwise go to IDLE (busy=0).
- Back-to-back grants are therefore separated by exactly one en=0 cycle. With all channels requesting, the cycle period per channel is DWELL+1.
- DWELL=1: each grant lasts exactly one cycle.
- A requester dropping req after its grant started shortens the grant. A requester that re-raises req before its next turn waits for the full rotation.
- Reset mid-operation: en/gnt drop asynchronously and last returns to 3. The first grant after reset release goes to the lowest-indexed requesting channel, starting from 0.
- Invariants the verifier checks every cycle:
  - gnt is one-hot or zero.
  - en == |gnt.
  - gnt is never nonzero on two consecutive grants without an intervening en=0 cycle.

Test Plan (DWELL=4):
- Reset release, req=4'b0001 held → en=1 starting one edge after req is sampled, {s0,s1}=00, gnt=0001 for 4 cycles, 1 gap cycle, then re-granted to channel 0 (repeating 4-on/1-off).
- req=4'b1111 held → grant order 0,1,2,3,0; each grant 4 cycles with en=0 gap; gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- Only req[2], deasserted after 2 grant cycles → gnt=0100 for exactly 2 cycles, GAP, then IDLE with busy=0 and s0=1, s1=0 held.
- Wrap-around: after a grant to channel 1 (last=1), req=4'b1001 → channel 3 granted next, then channel 0.
- rst asserted mid-grant (cycle 2 of channel 2), between clock edges → en=0, gnt=0, busy=0 immediately. After release with req=4'b0110, channel 1 is granted first.
- Simultaneous dwell expiry and req[sel] drop on the same edge → a single GAP cycle, no extra grant cycle, next channel granted normally.

Source files
------------

// File: rtl/rr_mux_sel_sequencer_if.sv
// Request/grant bundle between the requesters and the mux select sequencer.
interface rr_mux_sel_sequencer_if;
  logic [3:0] req;
  logic       en;
  logic       s0;
  logic       s1;
  logic [3:0] gnt;
  logic       busy;

  modport master (output req, input en, s0, s1, gnt, busy);
  modport slave  (input req, output en, s0, s1, gnt, busy);
endinterface

// File: rtl/rr_mux_sel_sequencer.sv
// Round-robin sequencer driving en/s0/s1 of a decoder-based 4:1 tristate mux,
// with bounded dwell per grant and a one-cycle en=0 gap between grants.
module rr_mux_sel_sequencer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_mux_sel_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state;
  logic [1:0]      sel;
  logic [1:0]      last;
  logic [CW-1:0]   cnt;
  logic            en_q;
  logic            busy_q;
  logic [3:0]      gnt_q;
  logic [1:0]      pick;

  // Scanning from the farthest offset down lets the nearest requester win.
  function automatic logic [1:0] arb(input logic [1:0] l, input logic [3:0] r);
    logic [1:0] idx;
    arb = l;
    for (int unsigned k = 4; k >= 1; k--) begin
      idx = l + 2'(k);
      if (r[idx]) arb = idx;
    end
  endfunction

  assign pick = arb(last, bus.req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      last   <= 2'd3;
      cnt    <= '0;
      en_q   <= 1'b0;
      gnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state  <= GRANT;
            sel    <= pick;
            cnt    <= '0;
            en_q   <= 1'b1;
            gnt_q  <= 4'b0001 << pick;
            busy_q <= 1'b1;
          end
        end
        GRANT: begin
          if (cnt == CW'(DWELL - 1) || !bus.req[sel]) begin
            state <= GAP;
            en_q  <= 1'b0;
            gnt_q <= '0;
            last  <= sel;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          // last already holds the channel just released.
          if (|bus.req) begin
            state <= GRANT;
            sel   <= pick;
            cnt   <= '0;
            en_q  <= 1'b1;
            gnt_q <= 4'b0001 << pick;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.en   = en_q;
  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.s0   = sel[1];
  assign bus.s1   = sel[0];

endmodule

// File: tb/tb_rr_mux_sel_sequencer.sv
// Scoreboard bench for rr_mux_sel_sequencer with DWELL=4.
module tb_rr_mux_sel_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rr_mux_sel_sequencer_if bus ();

  rr_mux_sel_sequencer #(.DWELL(4), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [7:0] exp;
  } item_t;

  item_t      stim[$];
  logic [7:0] expq[$];
  logic [7:0] obs;
  logic [7:0] want;
  logic [3:0] prev_gnt;

  // Expected {en, gnt, busy, s0, s1}.
  function automatic logic [7:0] mk(input logic e, input logic b, input logic [1:0] s);
    mk = {e, e ? (4'b0001 << s) : 4'b0000, b, s};
  endfunction

  task automatic add(input logic [3:0] r, input logic [7:0] x);
    item_t it;
    it.req = r;
    it.exp = x;
    stim.push_back(it);
  endtask

  task automatic add_grant(input logic [3:0] r, input logic [1:0] ch, input int n);
    repeat (n) add(r, mk(1'b1, 1'b1, ch));
    add(r, mk(1'b0, 1'b1, ch));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    bus.req = 4'b0000;
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_gnt = 4'b0000;
    end else begin
      total++;
      if (!$onehot0(bus.gnt)) begin
        bad++;
        $display("FAIL inv_onehot gnt=%b want one-hot or zero", bus.gnt);
      end
      total++;
      if (bus.en !== (|bus.gnt)) begin
        bad++;
        $display("FAIL inv_en en=%b want %b (gnt=%b)", bus.en, |bus.gnt, bus.gnt);
      end
      total++;
      if (prev_gnt != 4'b0000 && bus.gnt != 4'b0000 && prev_gnt != bus.gnt) begin
        bad++;
        $display("FAIL inv_gap gnt %b -> %b want an en=0 cycle between", prev_gnt, bus.gnt);
      end
      prev_gnt = bus.gnt;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
    #3;
    obs = {bus.en, bus.gnt, bus.busy, bus.s0, bus.s1};
    total++;
    if (obs !== mk(1'b0, 1'b0, 2'd0)) begin
      bad++;
      $display("FAIL reset got=%b want=%b", obs, mk(1'b0, 1'b0, 2'd0));
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    stim.delete();
    add_grant(4'b0001, 2'd0, 4);
    add_grant(4'b0001, 2'd0, 4);
    add(4'b0000, mk(1'b0, 1'b0, 2'd0));
    foreach (stim[i]) begin
      expq.push_back(stim[i].exp);
      bus.req = stim[i].req;
      @(posedge clk);
      #1;
      obs  = {bus.en, bus.gnt, bus.busy, bus.s0, bus.s1};
      want = expq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL single[%0d] got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_all();
    do_reset();
    stim.delete();
    for (int ch = 0; ch < 4; ch++) add_grant(4'b1111, 2'(ch), 4);
    add_grant(4'b1111, 2'd0, 4);
    add(4'b0000, mk(1'b0, 1'b0, 2'd0));
    foreach (stim[i]) begin
      expq.push_back(stim[i].exp);
      bus.req = stim[i].req;
      @(posedge clk);
      #1;
      obs  = {bus.en, bus.gnt, bus.busy, bus.s0, bus.s1};
      want = expq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL all_req[%0d] got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    stim.delete();
    add(4'b0100, mk(1'b1, 1'b1, 2'd2));
    add(4'b0100, mk(1'b1, 1'b1, 2'd2));
    add(4'b0000, mk(1'b0, 1'b1, 2'd2));
    add(4'b0000, mk(1'b0, 1'b0, 2'd2));
    add(4'b0000, mk(1'b0, 1'b0, 2'd2));
    foreach (stim[i]) begin
      expq.push_back(stim[i].exp);
      bus.req = stim[i].req;
      @(posedge clk);
      #1;
      obs  = {bus.en, bus.gnt, bus.busy, bus.s0, bus.s1};
      want = expq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL drop[%0d] got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    stim.delete();
    add(4'b0010, mk(1'b1, 1'b1, 2'd1));
    add(4'b1001, mk(1'b0, 1'b1, 2'd1));
    add_grant(4'b1001, 2'd3, 4);
    add_grant(4'b1001, 2'd0, 4);
    add(4'b0000, mk(1'b0, 1'b0, 2'd0));
    foreach (stim[i]) begin
      expq.push_back(stim[i].exp);
      bus.req = stim[i].req;
      @(posedge clk);
      #1;
      obs  = {bus.en, bus.gnt, bus.busy, bus.s0, bus.s1};
      want = expq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL wrap[%0d] got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    stim.delete();
    add(4'b0100, mk(1'b1, 1'b1, 2'd2));
    add(4'b0100, mk(1'b1, 1'b1, 2'd2));
    foreach (stim[i]) begin
      expq.push_back(stim[i].exp);
      bus.req = stim[i].req;
      @(posedge clk);
      #1;
      obs  = {bus.en, bus.gnt, bus.busy, bus.s0, bus.s1};
      want = expq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL rst_mid_pre[%0d] got=%b want=%b", i, obs, want);
      end
    end
    #2 rst = 1'b1;
    #1;
    obs = {bus.en, bus.gnt, bus.busy, bus.s0, bus.s1};
    total++;
    if (obs !== mk(1'b0, 1'b0, 2'd0)) begin
      bad++;
      $display("FAIL rst_mid_async got=%b want=%b", obs, mk(1'b0, 1'b0, 2'd0));
    end
    bus.req = 4'b0110;
    #2 rst = 1'b0;
    stim.delete();
    add_grant(4'b0110, 2'd1, 4);
    add_grant(4'b0110, 2'd2, 4);
    add(4'b0000, mk(1'b0, 1'b0, 2'd2));
    foreach (stim[i]) begin
      expq.push_back(stim[i].exp);
      bus.req = stim[i].req;
      @(posedge clk);
      #1;
      obs  = {bus.en, bus.gnt, bus.busy, bus.s0, bus.s1};
      want = expq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL rst_mid_post[%0d] got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_simul();
    do_reset();
    stim.delete();
    repeat (4) add(4'b0011, mk(1'b1, 1'b1, 2'd0));
    add(4'b0010, mk(1'b0, 1'b1, 2'd0));
    add_grant(4'b0010, 2'd1, 4);
    add(4'b0000, mk(1'b0, 1'b0, 2'd1));
    foreach (stim[i]) begin
      expq.push_back(stim[i].exp);
      bus.req = stim[i].req;
      @(posedge clk);
      #1;
      obs  = {bus.en, bus.gnt, bus.busy, bus.s0, bus.s1};
      want = expq.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL simul[%0d] got=%b want=%b", i, obs, want);
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    prev_gnt = 4'b0000;
    test_reset();
    test_single();
    test_all();
    test_drop();
    test_wrap();
    test_rst_mid();
    test_simul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
